// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration-chain serializer.
// The CRC constants and step function are used only when
// CONFIG_SERIALIZER_CRC_EN is defined.
package cfg_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int CNT_W_DEF  = 20;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One bit of CRC-16-CCITT, MSB-first register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cfg_shift_tick.sv
// Bit-rate prescaler: while enabled, emits a single-cycle tick every
// SHIFT_DIV clocks, the first one SHIFT_DIV-1 cycles after enable rises.
module cfg_shift_tick #(
  parameter int SHIFT_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int                DIV_W    = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SHIFT_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Divider counter: held at zero while disabled so every enable window starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  assign tick = enable && (div_cnt == DIV_LAST);

endmodule

// File: rtl/config_serializer.sv
// Host-side transmitter for the fabric configuration scan chain.
// Takes parallel words over valid/ready, shifts them LSB-first on config_out
// with one config_en strobe per bit until num_bits bits have gone out.
// Optional: define CONFIG_SERIALIZER_CRC_EN to add a CRC-16-CCITT output
// covering every shifted bit.
module config_serializer
  import cfg_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int SHIFT_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_bits,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              config_out,
  output logic              config_en,
  output logic              busy,
  output logic              done
`ifdef CONFIG_SERIALIZER_CRC_EN
  ,
  output logic [15:0]       crc
`endif
);

  localparam int               IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [IDX_W-1:0]  bit_idx;
  logic [WORD_W-1:0] shreg;
  logic              out_q;
  logic              tick;
  logic              start_ok;
  logic              accept;
  logic              shift_fire;

  cfg_shift_tick #(.SHIFT_DIV(SHIFT_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (state == SHIFT),
    .tick   (tick)
  );

  assign start_ok   = (state == IDLE) && start && !abort;
  assign accept     = word_valid && word_ready;
  assign shift_fire = tick && !abort;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; abort overrides everything except reset.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = (num_bits != '0) ? LOAD : DONE;
      LOAD:  if (abort) state_nxt = IDLE;
             else if (word_valid) state_nxt = SHIFT;
      SHIFT: if (abort) state_nxt = IDLE;
             else if (tick) begin
               if (remaining == CNT_W'(1))  state_nxt = DONE;
               else if (bit_idx == IDX_LAST) state_nxt = LOAD;
             end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; config_out shows the new bit on its tick and holds otherwise.
  always_comb begin
    word_ready = 1'b0;
    config_en  = 1'b0;
    config_out = out_q;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      LOAD:  word_ready = !abort;
      SHIFT: if (shift_fire) begin
               config_en  = 1'b1;
               config_out = shreg[0];
             end
      DONE:  done = !abort;
      default: ;
    endcase
  end

  // Datapath: bit budget, word shift register and bit position.
  // NOTE: shreg is an ordinary register (not a memory array), so it is reset with the rest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      out_q     <= 1'b0;
    end else begin
      if (start_ok) remaining <= num_bits;
      if (accept) begin
        shreg   <= word_data;
        bit_idx <= '0;
      end else if (shift_fire) begin
        shreg     <= shreg >> 1;
        bit_idx   <= bit_idx + IDX_W'(1);
        remaining <= remaining - CNT_W'(1);
        out_q     <= shreg[0];
      end
    end
  end

`ifdef CONFIG_SERIALIZER_CRC_EN
  // Running CRC over shifted bits; restarts on an accepted start, holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            crc <= CRC_INIT;
    else if (start_ok)   crc <= CRC_INIT;
    else if (shift_fire) crc <= crc16_step(crc, shreg[0]);
  end
`endif

endmodule

// File: tb/tb_config_serializer.sv
// Self-checking bench for config_serializer: a table of load scenarios on a
// SHIFT_DIV=1 instance with a bit scoreboard, plus hand-written sequences on a
// SHIFT_DIV=3 instance for prescaler timing, abort and start-while-busy.
module tb_config_serializer;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- DUT A (SHIFT_DIV = 1) ----------------
  logic              start = 0, abort = 0, word_valid = 0;
  logic [CNT_W-1:0]  num_bits = '0;
  logic [WORD_W-1:0] word_data = '0;
  logic              word_ready, config_out, config_en, busy, done;
  logic [15:0]       crc_a;

  config_serializer #(.WORD_W(WORD_W), .CNT_W(CNT_W), .SHIFT_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .num_bits(num_bits), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .config_out(config_out), .config_en(config_en), .busy(busy), .done(done)
`ifdef CONFIG_SERIALIZER_CRC_EN
    , .crc(crc_a)
`endif
  );

  // ---------------- DUT B (SHIFT_DIV = 3) ----------------
  logic              b_start = 0, b_abort = 0, b_word_valid = 0;
  logic [CNT_W-1:0]  b_num_bits = '0;
  logic [WORD_W-1:0] b_word_data = '0;
  logic              b_word_ready, b_config_out, b_config_en, b_busy, b_done;
  logic [15:0]       crc_b;

  config_serializer #(.WORD_W(WORD_W), .CNT_W(CNT_W), .SHIFT_DIV(3)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .num_bits(b_num_bits), .abort(b_abort),
    .word_data(b_word_data), .word_valid(b_word_valid), .word_ready(b_word_ready),
    .config_out(b_config_out), .config_en(b_config_en), .busy(b_busy), .done(b_done)
`ifdef CONFIG_SERIALIZER_CRC_EN
    , .crc(crc_b)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference CRC-16-CCITT, one bit at a time.
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic b);
    logic [15:0] n;
    n = {c[14:0], 1'b0};
    if (c[15] ^ b) n = n ^ 16'h1021;
    return n;
  endfunction

  // ---------------- Monitor / scoreboard for DUT A ----------------
  logic sb[$];
  int   en_cyc[$];
  int   en_cnt, done_cnt, done_cyc;
  logic ready_seen, last_out, exp_bit;

  always @(negedge clk) begin
    if (!rst) begin
      last_out = 1'b0;
    end else begin
      if (word_ready) ready_seen = 1'b1;
      if (config_en) begin
        en_cnt++;
        en_cyc.push_back(cyc);
        last_out = config_out;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: config_en=1 with no expected bit (cycle %0d)", cyc);
        end else begin
          exp_bit = sb.pop_front();
          check("config_out", config_out, exp_bit);
        end
      end else begin
        check("config_out_hold", config_out, last_out);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- Monitor for DUT B ----------------
  int   b_en_cyc[$];
  logic b_bits[$];
  int   b_done_cnt = 0, b_done_cyc = -1;

  always @(negedge clk) begin
    if (rst) begin
      if (b_config_en) begin
        b_en_cyc.push_back(cyc);
        b_bits.push_back(b_config_out);
      end
      if (b_done) begin
        b_done_cnt++;
        b_done_cyc = cyc;
      end
    end
  end

  // ---------------- Table-driven scenarios ----------------
  typedef struct {
    int          nbits;
    int          nwords;
    logic [31:0] w0;
    logic [31:0] w1;
    int          stall;
    int          exp_en;
  } vec_t;

  vec_t vecs[6];
  logic [15:0] crc_model;

  task automatic run_row(input vec_t v, input string tag);
    int          rem, tmo;
    int          acc_cyc[2];
    logic [31:0] wd;
    rem = v.nbits;
    sb.delete();
    en_cyc.delete();
    en_cnt = 0; done_cnt = 0; done_cyc = -1; ready_seen = 1'b0;
    crc_model = 16'hFFFF;
    acc_cyc[0] = 0; acc_cyc[1] = 0;

    start = 1'b1; num_bits = CNT_W'(v.nbits);
    acc_cyc[0] = cyc;  // reused as start cycle for the zero-length case
    step();
    start = 1'b0;
    if (v.nbits == 0) begin
      tmo = 0;
      while (done_cnt == 0 && tmo < 50) begin step(); tmo++; end
      check({tag, "_zero_done_cyc"}, done_cyc, acc_cyc[0] + 1);
    end

    for (int w = 0; w < v.nwords; w++) begin
      tmo = 0;
      while (!word_ready && tmo < 200) begin step(); tmo++; end
      check({tag, "_word_ready"}, word_ready, 1'b1);
      if (w == 0 && v.stall > 0) begin
        repeat (v.stall) step();
        check({tag, "_stall_en_cnt"}, en_cnt, 0);
        check({tag, "_stall_ready"}, word_ready, 1'b1);
      end
      wd = (w == 0) ? v.w0 : v.w1;
      word_data = wd; word_valid = 1'b1;
      for (int b = 0; b < WORD_W && rem > 0; b++) begin
        sb.push_back(wd[b]);
        crc_model = crc_ref(crc_model, wd[b]);
        rem--;
      end
      acc_cyc[w] = cyc;
      step();
      word_valid = 1'b0;
    end

    tmo = 0;
    while (done_cnt == 0 && tmo < 3000) begin step(); tmo++; end
    check({tag, "_done_seen"}, (done_cnt != 0), 1'b1);
    step(); step();

    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_en_count"}, en_cnt, v.exp_en);
    check({tag, "_sb_drained"}, sb.size(), 0);
    if (v.nbits == 0) begin
      check({tag, "_no_ready"}, ready_seen, 1'b0);
    end else begin
      check({tag, "_first_en_lat"}, en_cyc[0], acc_cyc[0] + 1);
      check({tag, "_done_lat"}, done_cyc, en_cyc[en_cyc.size()-1] + 1);
    end
    if (v.nwords > 1) begin
      check({tag, "_load_bubble"}, en_cyc[32] - en_cyc[31], 2);
      check({tag, "_second_word_lat"}, en_cyc[32], acc_cyc[1] + 1);
    end
`ifdef CONFIG_SERIALIZER_CRC_EN
    check({tag, "_crc"}, crc_a, crc_model);
`endif
  endtask

  task automatic wait_b(input string name, input int what);
    int tmo;
    tmo = 0;
    while (((what == 0) ? !b_word_ready : (b_done_cnt < what)) && tmo < 500) begin
      step(); tmo++;
    end
    if (what == 0) check(name, b_word_ready, 1'b1);
    else           check(name, b_done_cnt, what);
  endtask

  initial begin
    int   k, tmo;
    logic exp_b[3];

    vecs[0] = '{nbits: 8,  nwords: 1, w0: 32'h000000A5, w1: 32'h0,        stall: 0,  exp_en: 8};
    vecs[1] = '{nbits: 40, nwords: 2, w0: 32'hFFFFFFFF, w1: 32'h00000055, stall: 0,  exp_en: 40};
    vecs[2] = '{nbits: 4,  nwords: 1, w0: 32'h00000009, w1: 32'h0,        stall: 10, exp_en: 4};
    vecs[3] = '{nbits: 0,  nwords: 0, w0: 32'h0,        w1: 32'h0,        stall: 0,  exp_en: 0};
    vecs[4] = '{nbits: 32, nwords: 1, w0: 32'h12345678, w1: 32'h0,        stall: 0,  exp_en: 32};
    vecs[5] = '{nbits: 33, nwords: 2, w0: 32'h80000001, w1: 32'h00000001, stall: 0,  exp_en: 33};
    exp_b = '{1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (3) step();
    check("rst_word_ready", word_ready, 1'b0);
    check("rst_config_en",  config_en,  1'b0);
    check("rst_config_out", config_out, 1'b0);
    check("rst_busy",       busy,       1'b0);
    check("rst_done",       done,       1'b0);
    rst = 1'b1;
    step();
    check("idle_busy", busy, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_row(vecs[i], $sformatf("row%0d", i));
      step();
    end

    // Reset in the middle of a shift
    sb.delete();
    start = 1'b1; num_bits = CNT_W'(40);
    step();
    start = 1'b0;
    tmo = 0;
    while (!word_ready && tmo < 50) begin step(); tmo++; end
    check("mid_rst_ready", word_ready, 1'b1);
    word_data = 32'hFFFFFFFF; word_valid = 1'b1;
    for (int b = 0; b < 32; b++) sb.push_back(1'b1);
    step();
    word_valid = 1'b0;
    repeat (5) step();
    check("mid_rst_busy_before", busy, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_word_ready", word_ready, 1'b0);
    check("mid_rst_config_en",  config_en,  1'b0);
    check("mid_rst_config_out", config_out, 1'b0);
    check("mid_rst_busy",       busy,       1'b0);
    check("mid_rst_done",       done,       1'b0);
    step(); step();
    sb.delete();
    rst = 1'b1;
    step();
    run_row(vecs[0], "rerun");

    // DUT B: SHIFT_DIV=3, 3 bits of 0x6
    b_start = 1'b1; b_num_bits = CNT_W'(3);
    step();
    b_start = 1'b0;
    wait_b("b_ready1", 0);
    b_word_data = 32'h6; b_word_valid = 1'b1; k = cyc;
    step();
    b_word_valid = 1'b0;
    wait_b("b_done1", 1);
    step();
    check("b_en_count1", b_en_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b_en_cyc%0d", i), b_en_cyc[i], k + 3 * (i + 1));
      check($sformatf("b_bit%0d", i), b_bits[i], exp_b[i]);
    end
    check("b_done_lat", b_done_cyc, k + 10);

    // start while busy is ignored: 2 bits only
    b_start = 1'b1; b_num_bits = CNT_W'(2);
    step();
    b_start = 1'b0;
    wait_b("b_ready2", 0);
    b_word_data = 32'h3; b_word_valid = 1'b1;
    step();
    b_word_valid = 1'b0;
    step();
    b_start = 1'b1; b_num_bits = CNT_W'(7);
    step();
    b_start = 1'b0;
    wait_b("b_done2", 2);
    repeat (12) step();
    check("b_busy_start_ignored", b_busy, 1'b0);
    check("b_en_count2", b_en_cyc.size(), 5);
    check("b_done_count2", b_done_cnt, 2);

    // abort during a load, with a word offered in the same cycle
    b_start = 1'b1; b_num_bits = CNT_W'(5);
    step();
    b_start = 1'b0;
    wait_b("b_ready3", 0);
    b_word_data = 32'h1F; b_word_valid = 1'b1; b_abort = 1'b1;
    #1;
    check("b_abort_ready_forced", b_word_ready, 1'b0);
    step();
    b_abort = 1'b0; b_word_valid = 1'b0;
    check("b_abort_load_idle", b_busy, 1'b0);
    repeat (12) step();
    check("b_abort_load_en", b_en_cyc.size(), 5);
    check("b_abort_load_done", b_done_cnt, 2);

    // abort on a tick cycle in SHIFT
    b_start = 1'b1; b_num_bits = CNT_W'(5);
    step();
    b_start = 1'b0;
    wait_b("b_ready4", 0);
    b_word_data = 32'h1F; b_word_valid = 1'b1;
    step();
    b_word_valid = 1'b0;
    step(); step();
    b_abort = 1'b1;
    #1;
    check("b_abort_tick_en", b_config_en, 1'b0);
    step();
    b_abort = 1'b0;
    check("b_abort_shift_idle", b_busy, 1'b0);
    repeat (12) step();
    check("b_abort_shift_en", b_en_cyc.size(), 5);
    check("b_abort_shift_done", b_done_cnt, 2);

    // start and abort together in IDLE: abort wins
    b_start = 1'b1; b_abort = 1'b1; b_num_bits = CNT_W'(4);
    step();
    b_start = 1'b0; b_abort = 1'b0;
    check("b_start_abort_busy", b_busy, 1'b0);
    step();
    check("b_start_abort_ready", b_word_ready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/config_serializer.md
Name: config_serializer

Overview:
- Host-side transmitter for the fabric's serial configuration chain: the driving end of the `config_in` scan input of the fpga_250 top.
- Accepts parallel bitstream words over a valid/ready handshake.
- Shifts them out LSB-first on `config_out`, with a `config_en` strobe per bit, until a programmed total bit count is reached.
- Sits between the SoC/host bitstream source and the fabric top.

Parameters:
- WORD_W, 32, width of each bitstream word accepted from the host.
- CNT_W, 20, width of the total-bit counter (max chain length 2^CNT_W-1).
- SHIFT_DIV, 1, clk cycles per shifted bit (>=1); slows the chain clock-enable rate.

Ports:
- clk  in  1  single system clock, all logic rising-edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion synchronous to clk.
- start  in  1  one-cycle request to begin a bitstream load; ignored while busy.
- num_bits  in  CNT_W  total bits to shift; sampled on accepted start.
- abort  in  1  cancel current load; return to IDLE next cycle, no done.
- word_data  in  WORD_W  next bitstream word, bit 0 shifted first.
- word_valid  in  1  host has word_data available.
- word_ready  out  1  serializer will take word_data this cycle.
- config_out  out  1  serial config bit to fabric config_in.
- config_en  out  1  high for exactly one cycle per valid config_out bit.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after last bit shifted.

Behaviour:
- Reset (rst=0, async): state=IDLE; word_ready=0, config_out=0, config_en=0, busy=0, done=0; counters and shift register cleared.
- States:
  - IDLE: start=1 with num_bits>0 -> LOAD; remaining<=num_bits.
  - IDLE: start=1 with num_bits==0 -> DONE (no bits shifted).
  - LOAD: word_ready=1. word_valid&word_ready -> shreg<=word_data, bit_idx<=0, div_cnt<=0, -> SHIFT. Without word_valid, stays in LOAD indefinitely with config_en=0 (stall; no timeout).
  - SHIFT: word_ready=0. div_cnt counts 0..SHIFT_DIV-1. On div_cnt==SHIFT_DIV-1 (a tick): config_en=1, config_out=shreg[0], shreg>>=1, bit_idx++, remaining--.
    - After a tick with remaining==1: -> DONE; unshifted bits of the current word are discarded.
    - Else after a tick with bit_idx==WORD_W-1: -> LOAD.
  - DONE: done=1 for one cycle -> IDLE.
- config_out holds its last value between ticks and changes only on tick cycles.
- Latency (SHIFT_DIV=1):
  - start at cycle 0 -> word_ready at cycle 1.
  - Word accepted at cycle k -> first config_en at cycle k+1.
  - One dead cycle (LOAD) between words.
- abort: highest priority after rst. From any non-IDLE state -> IDLE next cycle; config_en=0 that cycle; done not pulsed. A word offered in the same cycle is not accepted (word_ready forced 0).
- start while busy: ignored, no effect on num_bits.
- start and abort in the same cycle in IDLE: abort wins, stay IDLE.
- rst asserted mid-SHIFT: outputs drop to reset values immediately (async). No partial state is retained.

Optional Feature:
- Macro CONFIG_SERIALIZER_CRC_EN.
- When defined:
  - Adds output crc [15:0]: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first register, one bit per tick) over every config_out bit actually shifted.
  - Reinitialised to 0xFFFF on accepted start.
  - Value holds after DONE until the next start.
- When undefined: no crc port and no CRC logic; behaviour otherwise identical.

Decomposition:
- Shared package cfg_pkg holds:
  - State enum (IDLE, LOAD, SHIFT, DONE).
  - CRC polynomial/init constants.
  - Default WORD_W/CNT_W.
- One natural sub-module: cfg_shift_tick, the SHIFT_DIV prescaler producing the single-cycle tick.
- FSM, counters and shift register stay in the top.

Test Plan:
- WORD_W=32, SHIFT_DIV=1, num_bits=8, word 0x000000A5 -> config_out on 8 config_en cycles = 1,0,1,0,0,1,0,1; done pulses 1 cycle after the 8th bit; busy=0 after that.
- num_bits=40, words 0xFFFFFFFF then 0x00000055 -> 32 ones, one LOAD bubble with config_en=0, then 1,0,1,0,1,0,1,0; done once.
- num_bits=4 with word_valid held low 10 cycles in LOAD -> config_en stays 0 throughout the stall; shifting resumes cycle after valid; total config_en count = 4.
- num_bits=0 start -> done pulse at cycle 1, word_ready never asserts, config_en never asserts.
- SHIFT_DIV=3, num_bits=3, word 0x6 -> config_en on cycles k+3, k+6, k+9 with bits 0,1,1; abort during a second load -> IDLE next cycle, no done.
- rst=0 mid-SHIFT, then release, then num_bits=8 run -> all outputs 0 during reset; the new run matches the first scenario exactly. With CONFIG_SERIALIZER_CRC_EN, crc matches a reference model for the 0xA5 stream.
